// File: rtl/decode_if.sv
// decode_if: fetch/regfile/execute-side signal bundle of the decode stage.
`default_nettype none

interface decode_if #(
   parameter int DW = 32
);
   logic [31:0]   instr_i;
   logic [DW-1:0] pc_i;
   logic          valid_i;
   logic [4:0]    rs1_addr_o;
   logic [4:0]    rs2_addr_o;
   logic [DW-1:0] rs1_data_i;
   logic [DW-1:0] rs2_data_i;
   logic          stall_i;
   logic          flush_i;
   logic          stall_o;
   logic          valid_o;
   logic [6:0]    opcode_o;
   logic          func7_5_o;
   logic [2:0]    alu_control_o;
   logic [DW-1:0] alu_operand_1_o;
   logic [DW-1:0] alu_operand_2_o;
   logic [DW-1:0] store_data_o;
   logic [4:0]    rd_addr_o;
   logic          reg_write_o;
   logic          mem_read_o;
   logic          mem_write_o;
   logic          branch_o;
   logic          jump_o;
   logic          illegal_o;

   modport master (
      output instr_i, pc_i, valid_i, rs1_data_i, rs2_data_i, stall_i, flush_i,
      input  rs1_addr_o, rs2_addr_o, stall_o, valid_o, opcode_o, func7_5_o,
             alu_control_o, alu_operand_1_o, alu_operand_2_o, store_data_o,
             rd_addr_o, reg_write_o, mem_read_o, mem_write_o, branch_o,
             jump_o, illegal_o
   );

   modport slave (
      input  instr_i, pc_i, valid_i, rs1_data_i, rs2_data_i, stall_i, flush_i,
      output rs1_addr_o, rs2_addr_o, stall_o, valid_o, opcode_o, func7_5_o,
             alu_control_o, alu_operand_1_o, alu_operand_2_o, store_data_o,
             rd_addr_o, reg_write_o, mem_read_o, mem_write_o, branch_o,
             jump_o, illegal_o
   );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : registered RV32I decode stage with stall/flush handling.
// Optional load-use interlock built when LOAD_USE_INTERLOCK_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_stage #(
   parameter int DW = 32
) (
   input  wire logic  clk,
   input  wire logic  rst,
   decode_if.slave    bus
);
   localparam logic [6:0] c_OP     = 7'b0110011;
   localparam logic [6:0] c_OP_IMM = 7'b0010011;
   localparam logic [6:0] c_LOAD   = 7'b0000011;
   localparam logic [6:0] c_STORE  = 7'b0100011;
   localparam logic [6:0] c_BRANCH = 7'b1100011;
   localparam logic [6:0] c_JAL    = 7'b1101111;
   localparam logic [6:0] c_JALR   = 7'b1100111;
   localparam logic [6:0] c_LUI    = 7'b0110111;
   localparam logic [6:0] c_AUIPC  = 7'b0010111;

   logic [31:0]   w_ins;
   logic [6:0]    w_opcode;
   logic [2:0]    w_f3;
   logic [4:0]    w_rd;
   logic [DW-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_shamt;
   logic [2:0]    w_alu;
   logic          w_f75;
   logic [DW-1:0] w_op1, w_op2;
   logic          w_rw, w_mr, w_mw, w_br, w_jp, w_il;
   logic          w_stall;

   assign w_ins    = bus.instr_i;
   assign w_opcode = w_ins[6:0];
   assign w_f3     = w_ins[14:12];
   assign w_rd     = w_ins[11:7];

   assign w_imm_i = DW'($signed(w_ins[31:20]));
   assign w_imm_s = DW'($signed({w_ins[31:25], w_ins[11:7]}));
   assign w_imm_b = DW'($signed({w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0}));
   assign w_imm_j = DW'($signed({w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}));
   assign w_imm_u = DW'($signed({w_ins[31:12], 12'h000}));
   assign w_shamt = DW'(w_ins[24:20]);

   assign bus.rs1_addr_o = w_ins[19:15];
   assign bus.rs2_addr_o = w_ins[24:20];

   always_comb begin
      w_alu = 3'd0;
      w_f75 = 1'b0;
      w_op1 = '0;
      w_op2 = '0;
      w_rw  = 1'b0;
      w_mr  = 1'b0;
      w_mw  = 1'b0;
      w_br  = 1'b0;
      w_jp  = 1'b0;
      w_il  = 1'b0;
      case (w_opcode)
         c_OP: begin
            w_alu = w_f3;
            w_f75 = w_ins[30];
            w_op1 = bus.rs1_data_i;
            w_op2 = bus.rs2_data_i;
            w_rw  = 1'b1;
         end
         c_OP_IMM: begin
            w_alu = w_f3;
            w_f75 = (w_f3 == 3'b101) ? w_ins[30] : 1'b0;
            w_op1 = bus.rs1_data_i;
            w_op2 = (w_f3 == 3'b001 || w_f3 == 3'b101) ? w_shamt : w_imm_i;
            w_rw  = 1'b1;
         end
         c_LOAD: begin
            w_op1 = bus.rs1_data_i;
            w_op2 = w_imm_i;
            w_mr  = 1'b1;
            w_rw  = 1'b1;
         end
         c_STORE: begin
            w_op1 = bus.rs1_data_i;
            w_op2 = w_imm_s;
            w_mw  = 1'b1;
         end
         c_BRANCH: begin
            w_op1 = bus.pc_i;
            w_op2 = w_imm_b;
            w_br  = 1'b1;
         end
         c_JAL: begin
            w_op1 = bus.pc_i;
            w_op2 = w_imm_j;
            w_jp  = 1'b1;
            w_rw  = 1'b1;
         end
         c_JALR: begin
            w_op1 = bus.rs1_data_i;
            w_op2 = w_imm_i;
            w_jp  = 1'b1;
            w_rw  = 1'b1;
         end
         c_LUI: begin
            w_op2 = w_imm_u;
            w_rw  = 1'b1;
         end
         c_AUIPC: begin
            w_op1 = bus.pc_i;
            w_op2 = w_imm_u;
            w_rw  = 1'b1;
         end
         default: w_il = 1'b1;
      endcase
   end

`ifdef LOAD_USE_INTERLOCK_EN
   logic w_use_rs1, w_use_rs2;

   assign w_use_rs1 = (w_opcode == c_OP) || (w_opcode == c_OP_IMM) || (w_opcode == c_LOAD) ||
                      (w_opcode == c_STORE) || (w_opcode == c_BRANCH) || (w_opcode == c_JALR);
   assign w_use_rs2 = (w_opcode == c_OP) || (w_opcode == c_STORE) || (w_opcode == c_BRANCH);

   // A flush kills the consumer, so there is nothing left to interlock.
   assign w_stall = bus.valid_o && bus.mem_read_o && bus.valid_i && !bus.flush_i &&
                    (bus.rd_addr_o != 5'd0) &&
                    ((w_use_rs1 && (bus.rd_addr_o == w_ins[19:15])) ||
                     (w_use_rs2 && (bus.rd_addr_o == w_ins[24:20])));
`else
   assign w_stall = 1'b0;
`endif

   assign bus.stall_o = w_stall;

   logic          r_valid;
   logic [6:0]    r_opcode;
   logic          r_f75;
   logic [2:0]    r_alu;
   logic [DW-1:0] r_op1, r_op2, r_sd;
   logic [4:0]    r_rd;
   logic          r_rw, r_mr, r_mw, r_br, r_jp, r_il;

   // Reset, flush and interlock all load the same all-zero bubble.
   always_ff @(posedge clk) begin
      if (rst || bus.flush_i || (!bus.stall_i && w_stall)) begin
         r_valid  <= 1'b0;
         r_opcode <= '0;
         r_f75    <= 1'b0;
         r_alu    <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_sd     <= '0;
         r_rd     <= '0;
         r_rw     <= 1'b0;
         r_mr     <= 1'b0;
         r_mw     <= 1'b0;
         r_br     <= 1'b0;
         r_jp     <= 1'b0;
         r_il     <= 1'b0;
      end else if (!bus.stall_i) begin
         r_valid  <= bus.valid_i;
         r_opcode <= w_opcode;
         r_f75    <= w_f75;
         r_alu    <= w_alu;
         r_op1    <= w_op1;
         r_op2    <= w_op2;
         r_sd     <= bus.rs2_data_i;
         r_rd     <= w_rd;
         r_rw     <= bus.valid_i && w_rw && (w_rd != 5'd0);
         r_mr     <= bus.valid_i && w_mr;
         r_mw     <= bus.valid_i && w_mw;
         r_br     <= bus.valid_i && w_br;
         r_jp     <= bus.valid_i && w_jp;
         r_il     <= bus.valid_i && w_il;
      end
   end

   assign bus.valid_o         = r_valid;
   assign bus.opcode_o        = r_opcode;
   assign bus.func7_5_o       = r_f75;
   assign bus.alu_control_o   = r_alu;
   assign bus.alu_operand_1_o = r_op1;
   assign bus.alu_operand_2_o = r_op2;
   assign bus.store_data_o    = r_sd;
   assign bus.rd_addr_o       = r_rd;
   assign bus.reg_write_o     = r_rw;
   assign bus.mem_read_o      = r_mr;
   assign bus.mem_write_o     = r_mw;
   assign bus.branch_o        = r_br;
   assign bus.jump_o          = r_jp;
   assign bus.illegal_o       = r_il;
endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// behavioural model of the decode rules and update priority.
`default_nettype none

module tb_decode_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_if #(.DW(32)) bus ();
   decode_stage #(.DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [31:0] rf [32];
   always_comb bus.rs1_data_i = rf[bus.instr_i[19:15]];
   always_comb bus.rs2_data_i = rf[bus.instr_i[24:20]];

   typedef struct packed {
      logic        valid;
      logic [6:0]  opcode;
      logic        f75;
      logic [2:0]  alu;
      logic [31:0] op1, op2, sd;
      logic [4:0]  rd;
      logic        rw, mr, mw, br, jp, il;
   } out_t;

   int   errors = 0;
   int   checks = 0;
   out_t m;

   function automatic out_t get_out();
      out_t o;
      o.valid = bus.valid_o;        o.opcode = bus.opcode_o;
      o.f75   = bus.func7_5_o;      o.alu    = bus.alu_control_o;
      o.op1   = bus.alu_operand_1_o; o.op2   = bus.alu_operand_2_o;
      o.sd    = bus.store_data_o;   o.rd     = bus.rd_addr_o;
      o.rw    = bus.reg_write_o;    o.mr     = bus.mem_read_o;
      o.mw    = bus.mem_write_o;    o.br     = bus.branch_o;
      o.jp    = bus.jump_o;         o.il     = bus.illegal_o;
      return o;
   endfunction

   function automatic out_t model_decode(logic [31:0] ins, logic [31:0] pc,
                                         logic [31:0] a, logic [31:0] b, logic v);
      out_t o = '0;
      logic [2:0]  f3   = ins[14:12];
      logic [31:0] immI = int'($signed(ins[31:20]));
      logic [31:0] immS = int'($signed({ins[31:25], ins[11:7]}));
      logic [31:0] immB = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      logic [31:0] immJ = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      logic [31:0] immU = {ins[31:12], 12'h000};
      o.valid = v; o.opcode = ins[6:0]; o.rd = ins[11:7]; o.sd = b;
      case (ins[6:0])
         7'h33: begin o.alu = f3; o.f75 = ins[30]; o.op1 = a; o.op2 = b; o.rw = 1; end
         7'h13: begin
            o.alu = f3; o.f75 = (f3 == 3'd5) && ins[30]; o.op1 = a; o.rw = 1;
            o.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : immI;
         end
         7'h03: begin o.op1 = a;  o.op2 = immI; o.mr = 1; o.rw = 1; end
         7'h23: begin o.op1 = a;  o.op2 = immS; o.mw = 1; end
         7'h63: begin o.op1 = pc; o.op2 = immB; o.br = 1; end
         7'h6F: begin o.op1 = pc; o.op2 = immJ; o.jp = 1; o.rw = 1; end
         7'h67: begin o.op1 = a;  o.op2 = immI; o.jp = 1; o.rw = 1; end
         7'h37: begin o.op1 = 0;  o.op2 = immU; o.rw = 1; end
         7'h17: begin o.op1 = pc; o.op2 = immU; o.rw = 1; end
         default: o.il = 1;
      endcase
      if (o.rd == 5'd0) o.rw = 0;
      if (!v) begin o.rw = 0; o.mr = 0; o.mw = 0; o.br = 0; o.jp = 0; o.il = 0; end
      return o;
   endfunction

   function automatic logic model_stall();
`ifdef LOAD_USE_INTERLOCK_EN
      logic [6:0] op = bus.instr_i[6:0];
      logic r1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
      logic r2 = op inside {7'h33, 7'h23, 7'h63};
      return m.valid && m.mr && bus.valid_i && !bus.flush_i && (m.rd != 0) &&
             ((r1 && m.rd == bus.instr_i[19:15]) || (r2 && m.rd == bus.instr_i[24:20]));
`else
      return 1'b0;
`endif
   endfunction

   // Advance one clock and the model by the update priority rules.
   task automatic tick();
      out_t nx;
      if (rst || bus.flush_i)  nx = '0;
      else if (bus.stall_i)    nx = m;
      else if (model_stall())  nx = '0;
      else nx = model_decode(bus.instr_i, bus.pc_i, rf[bus.instr_i[19:15]],
                             rf[bus.instr_i[24:20]], bus.valid_i);
      @(posedge clk);
      m = nx;
      #1;
   endtask

   task automatic drive(logic [31:0] ins, logic v, logic st, logic fl);
      bus.instr_i = ins; bus.valid_i = v; bus.stall_i = st; bus.flush_i = fl;
      bus.pc_i = $urandom & 32'hFFFF_FFFC;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive($urandom, 1'b1, 1'b0, 1'b0);
         tick();
      end
      checks++;
      if (get_out() !== out_t'('0)) begin
         errors++; $display("FAIL reset_outputs: got %h want 0", get_out());
      end
      rst = 1'b0;
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_o);
      end
   endtask

   task automatic test_sub();
      rf[1] = 32'd10; rf[2] = 32'd3;
      drive(32'h402081B3, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.rs1_addr_o !== 5'd1 || bus.rs2_addr_o !== 5'd2) begin
         errors++; $display("FAIL sub_rs_addr: got %0d/%0d want 1/2", bus.rs1_addr_o, bus.rs2_addr_o);
      end
      tick();
      checks++;
      if ({bus.valid_o, bus.alu_control_o, bus.func7_5_o, bus.alu_operand_1_o, bus.alu_operand_2_o,
           bus.rd_addr_o, bus.reg_write_o} !== {1'b1, 3'd0, 1'b1, 32'd10, 32'd3, 5'd3, 1'b1}) begin
         errors++;
         $display("FAIL sub_decode: got alu=%0d f75=%b op1=%0d op2=%0d rd=%0d rw=%b want 0 1 10 3 3 1",
                  bus.alu_control_o, bus.func7_5_o, bus.alu_operand_1_o, bus.alu_operand_2_o,
                  bus.rd_addr_o, bus.reg_write_o);
      end
   endtask

   task automatic test_imm();
      rf[6] = 32'h8000_0000;
      drive(32'h40435293, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if ({bus.alu_control_o, bus.func7_5_o, bus.alu_operand_1_o, bus.alu_operand_2_o} !==
          {3'd5, 1'b1, 32'h8000_0000, 32'd4}) begin
         errors++;
         $display("FAIL srai_decode: got alu=%0d f75=%b op1=%h op2=%h want 5 1 80000000 4",
                  bus.alu_control_o, bus.func7_5_o, bus.alu_operand_1_o, bus.alu_operand_2_o);
      end
      drive(32'h123453B7, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if ({bus.alu_operand_1_o, bus.alu_operand_2_o, bus.func7_5_o, bus.rd_addr_o, bus.reg_write_o} !==
          {32'd0, 32'h1234_5000, 1'b0, 5'd7, 1'b1}) begin
         errors++;
         $display("FAIL lui_decode: got op1=%h op2=%h f75=%b rd=%0d rw=%b want 0 12345000 0 7 1",
                  bus.alu_operand_1_o, bus.alu_operand_2_o, bus.func7_5_o, bus.rd_addr_o, bus.reg_write_o);
      end
   endtask

   task automatic test_load_use();
      logic exp_stall;
`ifdef LOAD_USE_INTERLOCK_EN
      exp_stall = 1'b1;
`else
      exp_stall = 1'b0;
`endif
      drive(32'h0000A203, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'h002202B3, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.stall_o !== exp_stall) begin
         errors++; $display("FAIL loaduse_stall: got %b want %b", bus.stall_o, exp_stall);
      end
      tick();
      if (exp_stall) begin
         checks++;
         if (bus.valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            errors++; $display("FAIL loaduse_bubble: got valid=%b stall=%b want 0 0", bus.valid_o, bus.stall_o);
         end
         tick();
      end
      checks++;
      if ({bus.valid_o, bus.opcode_o, bus.rd_addr_o, bus.reg_write_o} !== {1'b1, 7'h33, 5'd5, 1'b1}) begin
         errors++;
         $display("FAIL loaduse_add: got valid=%b opc=%h rd=%0d rw=%b want 1 33 5 1",
                  bus.valid_o, bus.opcode_o, bus.rd_addr_o, bus.reg_write_o);
      end
      // Hold beats interlock; then reset mid-interlock clears it.
      drive(32'h0000A203, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'h002202B3, 1'b1, 1'b1, 1'b0);
      tick();
      #1;
      checks++;
      if ({bus.valid_o, bus.mem_read_o, bus.rd_addr_o, bus.stall_o} !== {1'b1, 1'b1, 5'd4, exp_stall}) begin
         errors++;
         $display("FAIL loaduse_hold: got valid=%b mr=%b rd=%0d stall=%b want 1 1 4 %b",
                  bus.valid_o, bus.mem_read_o, bus.rd_addr_o, bus.stall_o, exp_stall);
      end
      rst = 1'b1;
      drive(32'h002202B3, 1'b1, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (get_out() !== out_t'('0) || bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL loaduse_reset: got %h stall=%b want 0 0", get_out(), bus.stall_o);
      end
   endtask

   task automatic test_stall_flush();
      out_t held;
      drive(32'h402081B3, 1'b1, 1'b0, 1'b0);
      tick();
      held = m;
      for (int i = 0; i < 3; i++) begin
         drive($urandom, 1'b1, 1'b1, 1'b0);
         tick();
         checks++;
         if (get_out() !== held) begin
            errors++; $display("FAIL stall_hold%0d: got %h want %h", i, get_out(), held);
         end
      end
      drive(32'h0000A203, 1'b1, 1'b1, 1'b1);
      tick();
      checks++;
      if (get_out() !== out_t'('0)) begin
         errors++; $display("FAIL stall_flush: got %h want 0", get_out());
      end
   endtask

   task automatic test_illegal();
      drive(32'h00000FFF, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if ({bus.illegal_o, bus.valid_o, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o,
           bus.branch_o, bus.jump_o} !== 7'b1100000) begin
         errors++;
         $display("FAIL illegal: got il=%b v=%b rw=%b mr=%b mw=%b br=%b jp=%b want 1 1 0 0 0 0 0",
                  bus.illegal_o, bus.valid_o, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o,
                  bus.branch_o, bus.jump_o);
      end
   endtask

   task automatic test_random();
      logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
      logic [31:0] ins;
      logic        es;
      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         ins[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
         ins[11:7]  = 5'($urandom_range(0, 5));
         ins[19:15] = 5'($urandom_range(0, 5));
         ins[24:20] = 5'($urandom_range(0, 5));
         drive(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 49) == 0);
         #1;
         es = rst ? 1'b0 : model_stall();
         if (!rst) begin
            checks++;
            if (bus.stall_o !== es) begin
               errors++; $display("FAIL rand_stall[%0d]: got %b want %b", n, bus.stall_o, es);
            end
         end
         tick();
         checks++;
         if (get_out() !== m) begin
            errors++; $display("FAIL rand_out[%0d]: got %h want %h", n, get_out(), m);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'd0;
      m = '0;
      rst = 1'b1;
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      #2;
      test_reset();
      test_sub();
      test_imm();
      test_load_use();
      test_stall_flush();
      test_illegal();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
